// File: rtl/ahb_bridge_pkg.sv
// rtl/ahb_bridge_pkg.sv - shared constants, output-stage states and gray-code helpers for the AHB bridge FIFOs
package ahb_bridge_pkg;

    localparam int REQ_W       = 66;
    localparam int RSP_W       = 33;
    localparam int DEF_P_SIZE  = 3;
    localparam int DEF_F_DEPTH = 4;
    localparam int GRAY_MAX_W  = 32;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_HOLD = 1'b1
    } out_state_e;

    // Callers zero-extend narrower pointers to GRAY_MAX_W and truncate the result;
    // leading zeros leave both conversions unaffected.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered binary/gray pointer pair with increment enable and binary load
module gray_counter
    import ahb_bridge_pkg::*;
#(
    parameter int W = DEF_P_SIZE
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_bin,
    output logic [W-1:0] o_bin,
    output logic [W-1:0] o_gray
);

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;

    // Load wins over increment so a flush can jump the pointer in one edge.
    always_comb begin
        bin_d = bin_q;
        if (i_load) begin
            bin_d = i_load_bin;
        end else if (i_en) begin
            bin_d = bin_q + W'(1);
        end
        gray_d = W'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign o_bin  = bin_q;
    assign o_gray = gray_q;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - read-domain controller of the gray-pointer CDC FIFO with a registered valid/ready output stage
module async_fifo_rd_ctrl
    import ahb_bridge_pkg::*;
#(
    parameter int DATA_W  = REQ_W,
    parameter int P_SIZE  = DEF_P_SIZE,
    parameter int F_DEPTH = DEF_F_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [P_SIZE-1:0] i_wr_gray_sync,
    input  logic [DATA_W-1:0] i_fifo_mem_sync [F_DEPTH-1:0],
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [P_SIZE-1:0] o_rd_gray_ptr,
    output logic              o_empty,
    output logic [P_SIZE-1:0] o_fill,
    output logic              o_ptr_err
);

    localparam int ADDR_W = P_SIZE - 1;

    if (F_DEPTH != (1 << ADDR_W)) begin : g_depth_chk
        $error("async_fifo_rd_ctrl: F_DEPTH must equal 2**(P_SIZE-1)");
    end

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ptr_err_q, ptr_err_d;
    logic [P_SIZE-1:0] rd_bin;
    logic [P_SIZE-1:0] wr_bin;
    logic              pop;

    assign wr_bin  = P_SIZE'(gray2bin(GRAY_MAX_W'(i_wr_gray_sync)));
    assign o_empty = (o_rd_gray_ptr == i_wr_gray_sync);
    assign o_fill  = wr_bin - rd_bin;
    assign o_valid = (state_q == OUT_HOLD);
    assign pop     = !o_empty && (!o_valid || i_ready) && !i_flush;

    gray_counter #(
        .W (P_SIZE)
    ) u_rd_ptr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (pop),
        .i_load     (i_flush),
        .i_load_bin (wr_bin),
        .o_bin      (rd_bin),
        .o_gray     (o_rd_gray_ptr)
    );

    // Flush discards the held entry even when i_ready is high in the same cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (i_flush) begin
            state_d = OUT_IDLE;
        end else if (pop) begin
            state_d = OUT_HOLD;
            data_d  = i_fifo_mem_sync[rd_bin[ADDR_W-1:0]];
        end else if ((state_q == OUT_HOLD) && i_ready) begin
            state_d = OUT_IDLE;
        end
    end

    // A legal gray pointer can never run more than F_DEPTH ahead of the reader.
    assign ptr_err_d = ptr_err_q || (int'(o_fill) > F_DEPTH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= OUT_IDLE;
            data_q    <= '0;
            ptr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ptr_err_q <= ptr_err_d;
        end
    end

    assign o_data    = data_q;
    assign o_ptr_err = ptr_err_q;

endmodule
